// File: rtl/alu_mul_sequencer.sv
// Shift-and-add 16x16 -> 16-bit unsigned multiplier that drives a shared datapath ALU.
// Optional signed operation is enabled with `define SIGNED_MUL_EN (adds in_signed and NEGA/NEGB/NEGP).
module alu_mul_sequencer #(
  parameter int unsigned WIDTH    = 16,
  parameter int unsigned MAX_ITER = 16
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
`ifdef SIGNED_MUL_EN
  input  logic             in_signed,
`endif
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_p,
  output logic             out_ovf,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  output logic [4:0]       alu_fs,
  output logic             alu_c0,
  input  logic [WIDTH-1:0] alu_f,
  input  logic [3:0]       alu_status
);

  localparam int unsigned CW = (MAX_ITER > 1) ? $clog2(MAX_ITER) : 1;
  localparam logic [CW-1:0] LAST = CW'(MAX_ITER - 1);

  localparam logic [4:0] FS_ADD = 5'b01000;
  localparam logic [4:0] FS_SHL = 5'b10000;
  localparam logic [4:0] FS_SHR = 5'b10100;
`ifdef SIGNED_MUL_EN
  localparam logic [4:0] FS_NEG = 5'b01001;
  localparam logic [WIDTH-1:0] MAG_MIN = {1'b1, {(WIDTH-1){1'b0}}};
`endif

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    ADD  = 3'd1,
    SHM  = 3'd2,
    SHQ  = 3'd3,
    DONE = 3'd4
`ifdef SIGNED_MUL_EN
    ,
    NEGA = 3'd5,
    NEGB = 3'd6,
    NEGP = 3'd7
`endif
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] m_q, m_d;
  logic [WIDTH-1:0] q_q, q_d;
  logic [WIDTH-1:0] p_q, p_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             ovf_q, ovf_d;

  logic             in_ready_q, in_ready_d;
  logic             out_valid_q, out_valid_d;
  logic [WIDTH-1:0] out_p_q, out_p_d;
  logic             out_ovf_q, out_ovf_d;
  logic [WIDTH-1:0] alu_a_q, alu_a_d;
  logic [WIDTH-1:0] alu_b_q, alu_b_d;
  logic [4:0]       alu_fs_q, alu_fs_d;
  logic             alu_c0_q, alu_c0_d;

`ifdef SIGNED_MUL_EN
  logic sgn_q, sgn_d;
  logic negb_q, negb_d;
  logic negres_q, negres_d;
`endif

  // Only carry and zero flags steer the sequence.
  logic unused_status;
  assign unused_status = alu_status[3] ^ alu_status[1];

  always_comb begin
    state_d = state_q;
    m_d     = m_q;
    q_d     = q_q;
    p_d     = p_q;
    cnt_d   = cnt_q;
    ovf_d   = ovf_q;
`ifdef SIGNED_MUL_EN
    sgn_d    = sgn_q;
    negb_d   = negb_q;
    negres_d = negres_q;
`endif
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          m_d   = in_a;
          q_d   = in_b;
          p_d   = '0;
          cnt_d = '0;
          ovf_d = 1'b0;
`ifdef SIGNED_MUL_EN
          sgn_d    = in_signed;
          negb_d   = in_signed & in_b[WIDTH-1];
          negres_d = in_signed & (in_a[WIDTH-1] ^ in_b[WIDTH-1]);
`endif
          if (in_b == '0)
            state_d = DONE;
`ifdef SIGNED_MUL_EN
          else if (in_signed && in_a[WIDTH-1])
            state_d = NEGA;
          else if (in_signed && in_b[WIDTH-1])
            state_d = NEGB;
`endif
          else
            state_d = in_b[0] ? ADD : SHM;
        end
      end
      ADD: begin
        p_d = alu_f;
        if (alu_status[2]) ovf_d = 1'b1;
        state_d = SHM;
      end
      SHM: begin
        m_d = alu_f;
        // A set bit leaving M is lost only if multiplier bits remain to consume it.
        if (m_q[WIDTH-1] && (q_q[WIDTH-1:1] != '0)) ovf_d = 1'b1;
        state_d = SHQ;
      end
      SHQ: begin
        q_d   = alu_f;
        cnt_d = cnt_q + 1'b1;
        if (alu_status[0] || (cnt_q == LAST)) begin
          state_d = DONE;
`ifdef SIGNED_MUL_EN
          if (sgn_q && p_q[WIDTH-1] && !(negres_q && (p_q == MAG_MIN))) ovf_d = 1'b1;
          if (negres_q) state_d = NEGP;
`endif
        end else begin
          state_d = alu_f[0] ? ADD : SHM;
        end
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
`ifdef SIGNED_MUL_EN
      // Negation preserves bit 0, so the loop entry can use the stored Q.
      NEGA: begin
        m_d     = alu_f;
        state_d = negb_q ? NEGB : (q_q[0] ? ADD : SHM);
      end
      NEGB: begin
        q_d     = alu_f;
        state_d = q_q[0] ? ADD : SHM;
      end
      NEGP: begin
        p_d     = alu_f;
        state_d = DONE;
      end
`endif
      default: state_d = IDLE;
    endcase
  end

  // ALU drive is registered from next-state values so it lines up with the state it serves.
  always_comb begin
    alu_a_d  = '0;
    alu_b_d  = '0;
    alu_fs_d = '0;
    alu_c0_d = 1'b0;
    case (state_d)
      ADD: begin
        alu_a_d  = p_d;
        alu_b_d  = m_d;
        alu_fs_d = FS_ADD;
      end
      SHM: begin
        alu_a_d  = m_d;
        alu_b_d  = WIDTH'(1);
        alu_fs_d = FS_SHL;
      end
      SHQ: begin
        alu_a_d  = q_d;
        alu_b_d  = WIDTH'(1);
        alu_fs_d = FS_SHR;
      end
`ifdef SIGNED_MUL_EN
      NEGA: begin
        alu_b_d  = m_d;
        alu_fs_d = FS_NEG;
        alu_c0_d = 1'b1;
      end
      NEGB: begin
        alu_b_d  = q_d;
        alu_fs_d = FS_NEG;
        alu_c0_d = 1'b1;
      end
      NEGP: begin
        alu_b_d  = p_d;
        alu_fs_d = FS_NEG;
        alu_c0_d = 1'b1;
      end
`endif
      default: ;
    endcase
    in_ready_d  = (state_d == IDLE);
    out_valid_d = (state_d == DONE);
    out_p_d     = (state_d == DONE) ? p_d : '0;
    out_ovf_d   = (state_d == DONE) ? ovf_d : 1'b0;
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      m_q         <= '0;
      q_q         <= '0;
      p_q         <= '0;
      cnt_q       <= '0;
      ovf_q       <= 1'b0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      out_p_q     <= '0;
      out_ovf_q   <= 1'b0;
      alu_a_q     <= '0;
      alu_b_q     <= '0;
      alu_fs_q    <= '0;
      alu_c0_q    <= 1'b0;
`ifdef SIGNED_MUL_EN
      sgn_q       <= 1'b0;
      negb_q      <= 1'b0;
      negres_q    <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      m_q         <= m_d;
      q_q         <= q_d;
      p_q         <= p_d;
      cnt_q       <= cnt_d;
      ovf_q       <= ovf_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      out_p_q     <= out_p_d;
      out_ovf_q   <= out_ovf_d;
      alu_a_q     <= alu_a_d;
      alu_b_q     <= alu_b_d;
      alu_fs_q    <= alu_fs_d;
      alu_c0_q    <= alu_c0_d;
`ifdef SIGNED_MUL_EN
      sgn_q       <= sgn_d;
      negb_q      <= negb_d;
      negres_q    <= negres_d;
`endif
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign out_p     = out_p_q;
  assign out_ovf   = out_ovf_q;
  assign alu_a     = alu_a_q;
  assign alu_b     = alu_b_q;
  assign alu_fs    = alu_fs_q;
  assign alu_c0    = alu_c0_q;

endmodule

// File: tb/tb_alu_mul_sequencer.sv
// Bench for alu_mul_sequencer: behavioural datapath ALU, directed vector table, handshake/reset sequences.
module tb_alu_mul_sequencer;

  logic        clock = 1'b0;
  logic        reset_n;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] in_a, in_b;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] out_p;
  logic        out_ovf;
  logic [15:0] alu_a, alu_b;
  logic [4:0]  alu_fs;
  logic        alu_c0;
  logic [15:0] alu_f;
  logic [3:0]  alu_status;

  alu_mul_sequencer #(.WIDTH(16), .MAX_ITER(16)) dut (
    .clock      (clock),
    .reset_n    (reset_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_a       (in_a),
    .in_b       (in_b),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_p      (out_p),
    .out_ovf    (out_ovf),
    .alu_a      (alu_a),
    .alu_b      (alu_b),
    .alu_fs     (alu_fs),
    .alu_c0     (alu_c0),
    .alu_f      (alu_f),
    .alu_status (alu_status)
  );

  always #5 clock = ~clock;

  // Datapath ALU: op = fs[4:2] (010 add, 100 shl, 101 shr), fs[1]/fs[0] invert A/B.
  logic [15:0] xa, xb;
  logic [16:0] sum;
  logic        cflag, vflag;
  always_comb begin
    xa  = alu_fs[1] ? ~alu_a : alu_a;
    xb  = alu_fs[0] ? ~alu_b : alu_b;
    sum = {1'b0, xa} + {1'b0, xb} + {16'b0, alu_c0};
    case (alu_fs[4:2])
      3'b010:  alu_f = sum[15:0];
      3'b100:  alu_f = xa << xb[3:0];
      3'b101:  alu_f = xa >> xb[3:0];
      default: alu_f = xa;
    endcase
    cflag = (alu_fs[4:2] == 3'b010) ? sum[16] : 1'b0;
    vflag = (alu_fs[4:2] == 3'b010) ? ((xa[15] == xb[15]) && (sum[15] != xa[15])) : 1'b0;
    alu_status = {vflag, cflag, alu_f[15], (alu_f == 16'h0000)};
  end

  int tests = 0;
  int fails = 0;
  logic [4:0] ops[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // Waits for in_ready, issues one operation and counts edges (accept edge = 1) until out_valid.
  task automatic do_op(input logic [15:0] a, input logic [15:0] b, output int lat);
    int guard;
    guard = 0;
    while (!in_ready && guard < 20) begin
      tick();
      guard++;
    end
    ops.delete();
    in_a = a;
    in_b = b;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    lat = 1;
    while (!out_valid && lat < 200) begin
      if (alu_fs != 5'b00000) ops.push_back(alu_fs);
      tick();
      lat++;
    end
    if (!out_valid) lat = -1;
  endtask

  typedef struct {
    logic [15:0] a;
    logic [15:0] b;
    logic [15:0] p;
    logic        ovf;
    int          lat;
  } vec_t;

  vec_t vecs[12];
  logic [4:0] exp_ops[8];

  initial begin
    int lat;
    int guard;
    logic stable;

    vecs[0]  = '{a: 16'h0003, b: 16'h0005, p: 16'h000F, ovf: 1'b0, lat: 9};
    vecs[1]  = '{a: 16'h1234, b: 16'h0000, p: 16'h0000, ovf: 1'b0, lat: 1};
    vecs[2]  = '{a: 16'h0100, b: 16'h0100, p: 16'h0000, ovf: 1'b1, lat: 20};
    vecs[3]  = '{a: 16'hFFFF, b: 16'hFFFF, p: 16'h0001, ovf: 1'b1, lat: 49};
    vecs[4]  = '{a: 16'h0007, b: 16'h0009, p: 16'h003F, ovf: 1'b0, lat: 11};
    vecs[5]  = '{a: 16'h00FF, b: 16'h0101, p: 16'hFFFF, ovf: 1'b0, lat: 21};
    vecs[6]  = '{a: 16'h8000, b: 16'h0002, p: 16'h0000, ovf: 1'b1, lat: 6};
    vecs[7]  = '{a: 16'h8000, b: 16'h0001, p: 16'h8000, ovf: 1'b0, lat: 4};
    vecs[8]  = '{a: 16'hFFFF, b: 16'h0002, p: 16'hFFFE, ovf: 1'b1, lat: 6};
    vecs[9]  = '{a: 16'h4000, b: 16'h0004, p: 16'h0000, ovf: 1'b1, lat: 8};
    vecs[10] = '{a: 16'h0001, b: 16'h8000, p: 16'h8000, ovf: 1'b0, lat: 34};
    vecs[11] = '{a: 16'h0003, b: 16'hC000, p: 16'h4000, ovf: 1'b1, lat: 35};
    exp_ops = '{5'b01000, 5'b10000, 5'b10100, 5'b10000, 5'b10100, 5'b01000, 5'b10000, 5'b10100};

    reset_n   = 1'b0;
    in_valid  = 1'b0;
    in_a      = '0;
    in_b      = '0;
    out_ready = 1'b1;

    // Reset state
    repeat (3) tick();
    check("reset_in_ready_held", {31'b0, in_ready}, 32'd1);
    reset_n = 1'b1;
    tick();
    check("reset_in_ready", {31'b0, in_ready}, 32'd1);
    check("reset_out_valid", {31'b0, out_valid}, 32'd0);
    check("reset_alu_fs", {27'b0, alu_fs}, 32'd0);
    check("reset_out_p", {16'b0, out_p}, 32'd0);
    check("reset_out_ovf", {31'b0, out_ovf}, 32'd0);

    // Basic multiply with ALU op order
    do_op(16'h0003, 16'h0005, lat);
    check("basic_p", {16'b0, out_p}, 32'h000F);
    check("basic_lat", lat, 32'd9);
    check("basic_nops", ops.size(), 32'd8);
    for (int i = 0; i < 8; i++)
      check($sformatf("basic_op%0d", i), {27'b0, (i < ops.size()) ? ops[i] : 5'h1F}, {27'b0, exp_ops[i]});

    // Zero multiplier issues no ALU ops
    do_op(16'h1234, 16'h0000, lat);
    check("zero_lat", lat, 32'd1);
    check("zero_nops", ops.size(), 32'd0);
    check("zero_p", {16'b0, out_p}, 32'd0);

    // Table
    for (int i = 0; i < 12; i++) begin
      do_op(vecs[i].a, vecs[i].b, lat);
      check($sformatf("vec%0d_p", i), {16'b0, out_p}, {16'b0, vecs[i].p});
      check($sformatf("vec%0d_ovf", i), {31'b0, out_ovf}, {31'b0, vecs[i].ovf});
      check($sformatf("vec%0d_lat", i), lat, vecs[i].lat);
    end

    // Backpressure: result held, in_valid ignored
    tick();
    out_ready = 1'b0;
    do_op(16'h0100, 16'h0100, lat);
    check("bp_lat", lat, 32'd20);
    in_a = 16'h0002;
    in_b = 16'h0003;
    in_valid = 1'b1;
    for (int c = 0; c < 10; c++) begin
      stable = out_valid && (out_p == 16'h0000) && out_ovf && !in_ready && (alu_fs == 5'b00000);
      check($sformatf("bp_hold%0d", c), {31'b0, stable}, 32'd1);
      tick();
    end
    out_ready = 1'b1;
    tick();
    check("bp_release_in_ready", {31'b0, in_ready}, 32'd1);
    check("bp_release_out_valid", {31'b0, out_valid}, 32'd0);
    check("bp_release_no_op", {27'b0, alu_fs}, 32'd0);
    in_valid = 1'b0;
    tick();
    check("bp_not_accepted", {31'b0, in_ready}, 32'd1);

    // Mid-operation reset during SHQ of 7*9
    in_a = 16'h0007;
    in_b = 16'h0009;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    guard = 0;
    while (alu_fs != 5'b10100 && guard < 20) begin
      tick();
      guard++;
    end
    check("mid_reached_shq", {27'b0, alu_fs}, 32'h14);
    reset_n = 1'b0;
    #1;
    check("mid_in_ready", {31'b0, in_ready}, 32'd1);
    check("mid_out_valid", {31'b0, out_valid}, 32'd0);
    check("mid_alu_fs", {27'b0, alu_fs}, 32'd0);
    #2;
    reset_n = 1'b1;
    stable = 1'b1;
    for (int c = 0; c < 12; c++) begin
      tick();
      if (out_valid || !in_ready) stable = 1'b0;
    end
    check("mid_no_result", {31'b0, stable}, 32'd1);
    do_op(16'h0007, 16'h0009, lat);
    check("mid_rerun_p", {16'b0, out_p}, 32'd63);
    check("mid_rerun_lat", lat, 32'd11);

    tick();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "timeout");
  end

endmodule
